decode_stage: RTL

- Pipelined, parametrised instruction decode stage for the MIPS-style datapath; sits between the fetch unit and the register-file and control stage.
- Decodes R-, I- and J-format instructions, where the earlier decoder handled R-format only. Adds sign/zero immediate extension, PC pass-through, flush and a decoded-instruction counter.
- Uses a valid/ready handshake on both sides, with a 2-entry skid buffer so in_ready is driven directly from a register.

---
 rtl/decode_pkg.sv | 38 +++
 rtl/decode_stage_if.sv | 35 +++
 rtl/decode_stage_field_decode.sv | 37 +++
 rtl/decode_stage.sv | 97 +++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: format codes, opcode constants and the decoded bundle.
package decode_pkg;

  localparam int INSTR_W = 32;
  localparam int REG_AW  = 5;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2,
    FMT_X = 2'd3
  } fmt_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  // Everything but the immediate, whose width depends on DATA_W.
  typedef struct packed {
    fmt_e              fmt;
    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [25:0]       jaddr;
  } fields_t;

  // Logical immediates are zero-extended; all others are sign-extended.
  function automatic logic is_zext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and downstream-side handshake bundle for the decode stage.
interface decode_stage_if #(
  parameter int PC_W   = 32,
  parameter int REG_AW = 5,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [1:0]        out_fmt;
  logic [5:0]        out_opcode;
  logic [REG_AW-1:0] out_rs;
  logic [REG_AW-1:0] out_rt;
  logic [REG_AW-1:0] out_rd;
  logic [4:0]        out_shamt;
  logic [5:0]        out_funct;
  logic [DATA_W-1:0] out_imm;
  logic [25:0]       out_jaddr;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_fmt, out_opcode, out_rs, out_rt,
           out_rd, out_shamt, out_funct, out_imm, out_jaddr
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_fmt, out_opcode, out_rs, out_rt,
           out_rd, out_shamt, out_funct, out_imm, out_jaddr
  );
endinterface

// File: rtl/decode_stage_field_decode.sv
// Combinational instruction word -> decoded bundle, with per-format field zeroing.
module instr_field_decode
  import decode_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output fields_t            f,
  output logic [DATA_W-1:0]  imm
);
  logic [5:0] op;
  assign op = instr[31:26];

  // Classify by opcode, then populate only the fields meaningful to that format.
  always_comb begin
    f        = '0;
    imm      = '0;
    f.opcode = op;
    if (op == OP_RTYPE) begin
      f.fmt   = FMT_R;
      f.rs    = instr[25:21];
      f.rt    = instr[20:16];
      f.rd    = instr[15:11];
      f.shamt = instr[10:6];
      f.funct = instr[5:0];
    end else if (op == OP_J || op == OP_JAL) begin
      f.fmt   = FMT_J;
      f.jaddr = instr[25:0];
    end else begin
      f.fmt = FMT_I;
      f.rs  = instr[25:21];
      f.rt  = instr[20:16];
      if (is_zext(op)) imm = DATA_W'(instr[15:0]);
      else             imm = DATA_W'($signed(instr[15:0]));
    end
  end
endmodule

// File: rtl/decode_stage.sv
// Decode stage: shared field decoder feeding a main/skid register pair.
module decode_stage
  import decode_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int REG_AW = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  decode_stage_if.slave    bus,
  output logic [CNT_W-1:0] dec_count
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_e;

  buf_e              st;
  fields_t           dec_f, main_f, skid_f;
  logic [DATA_W-1:0] dec_imm, main_imm, skid_imm;
  logic [PC_W-1:0]   main_pc, skid_pc;
  logic              rdy_q;
  logic              acc, drain;

  instr_field_decode #(.DATA_W(DATA_W)) u_dec (
    .instr (bus.in_instr),
    .f     (dec_f),
    .imm   (dec_imm)
  );

  // Flush kills any same-cycle input transfer; an output transfer still completes.
  assign acc   = bus.in_valid & rdy_q & ~flush;
  assign drain = (st != EMPTY) & bus.out_ready;

  // Buffer occupancy FSM; in_ready is registered as "skid will be free".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= EMPTY;
      rdy_q    <= 1'b1;
      main_f   <= '0;
      main_imm <= '0;
      main_pc  <= '0;
      skid_f   <= '0;
      skid_imm <= '0;
      skid_pc  <= '0;
    end else if (flush) begin
      st    <= EMPTY;
      rdy_q <= 1'b1;
    end else begin
      case (st)
        EMPTY: if (acc) begin
          main_f <= dec_f; main_imm <= dec_imm; main_pc <= bus.in_pc;
          st     <= ONE;
        end
        ONE: begin
          if (acc && drain) begin
            main_f <= dec_f; main_imm <= dec_imm; main_pc <= bus.in_pc;
          end else if (drain) begin
            st <= EMPTY;
          end else if (acc) begin
            skid_f <= dec_f; skid_imm <= dec_imm; skid_pc <= bus.in_pc;
            st     <= FULL;
            rdy_q  <= 1'b0;
          end
        end
        FULL: if (drain) begin
          main_f <= skid_f; main_imm <= skid_imm; main_pc <= skid_pc;
          st     <= ONE;
          rdy_q  <= 1'b1;
        end
        default: begin
          st    <= EMPTY;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of bundles handed downstream; flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       dec_count <= '0;
    else if (drain && ~&dec_count)    dec_count <= dec_count + 1'b1;
  end

  assign bus.in_ready   = rdy_q;
  assign bus.out_valid  = (st != EMPTY);
  assign bus.out_pc     = main_pc;
  assign bus.out_fmt    = main_f.fmt;
  assign bus.out_opcode = main_f.opcode;
  assign bus.out_rs     = REG_AW'(main_f.rs);
  assign bus.out_rt     = REG_AW'(main_f.rt);
  assign bus.out_rd     = REG_AW'(main_f.rd);
  assign bus.out_shamt  = main_f.shamt;
  assign bus.out_funct  = main_f.funct;
  assign bus.out_imm    = main_imm;
  assign bus.out_jaddr  = main_f.jaddr;
endmodule
